// File: rtl/com_to_in.sv
// com_to_in: oversampling serial receiver for the host COM line.
// Frame: start(0), 8 data bits LSB first, optional even parity bit, stop(1).
// Parity support is compiled in with `define COM_RX_PARITY_EN; without it the
// frame is start + 8 data + stop and parErr is held at 0.
// All protocol state advances only on clk edges where enable is high; the
// input synchronizer and the isReady pulse run on every clk.
`timescale 1ns/1ps

module com_to_in #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       isReady,
  output logic       parErr,
  output logic       frameErr
);

  localparam int unsigned CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  // Tick on which the start bit is re-checked (its mid-point).
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  // Tick on which every later bit is sampled (one full bit after the last).
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    sync_q;
  logic          rxs;

  state_t        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [2:0]    idx_q,      idx_d;
  logic [7:0]    sh_q,       sh_d;
  logic [7:0]    data_q,     data_d;
  logic          frameerr_q, frameerr_d;
  logic          isready_q,  isready_d;
`ifdef COM_RX_PARITY_EN
  logic          pbit_q,     pbit_d;
  logic          parerr_q,   parerr_d;
`endif

  logic          bit_last;

  assign rxs      = sync_q[1];
  assign bit_last = (cnt_q == BIT_LAST);

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  // Receiver state, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      data_q     <= '0;
      frameerr_q <= 1'b0;
      isready_q  <= 1'b0;
`ifdef COM_RX_PARITY_EN
      pbit_q     <= 1'b0;
      parerr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      frameerr_q <= frameerr_d;
      isready_q  <= isready_d;
`ifdef COM_RX_PARITY_EN
      pbit_q     <= pbit_d;
      parerr_q   <= parerr_d;
`endif
    end
  end

  // Next-state logic: deframing sequence, evaluated only on enable ticks.
  // isReady defaults low every clk so the pulse lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    data_d     = data_q;
    frameerr_d = frameerr_q;
    isready_d  = 1'b0;
`ifdef COM_RX_PARITY_EN
    pbit_d     = pbit_q;
    parerr_d   = parerr_q;
`endif

    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end

        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            if (!rxs) begin
              state_d = S_DATA;
              idx_d   = '0;
            end else begin
              // Glitch shorter than half a bit: not a real start bit.
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_DATA: begin
          if (bit_last) begin
            sh_d  = {rxs, sh_q[7:1]};
            cnt_d = '0;
            if (idx_q == 3'd7) begin
`ifdef COM_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

`ifdef COM_RX_PARITY_EN
        S_PARITY: begin
          if (bit_last) begin
            pbit_d  = rxs;
            cnt_d   = '0;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (bit_last) begin
            data_d     = sh_q;
            frameerr_d = ~rxs;
            isready_d  = 1'b1;
`ifdef COM_RX_PARITY_EN
            parerr_d   = (^sh_q) ^ pbit_q;
`endif
            cnt_d      = '0;
            // A low stop bit means the line may be held low (break); wait
            // for it to return high before hunting for the next start bit.
            state_d    = rxs ? S_IDLE : S_BREAK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_BREAK: begin
          if (rxs) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign data     = data_q;
  assign isReady  = isready_q;
  assign frameErr = frameerr_q;
`ifdef COM_RX_PARITY_EN
  assign parErr   = parerr_q;
`else
  assign parErr   = 1'b0;
`endif

endmodule

// File: tb/tb_com_to_in.sv
// Self-checking bench for com_to_in: drives whole serial frames on rx with a
// randomly gated enable tick and compares every isReady pulse against a queue
// of expected results computed from the frame that was sent.
`timescale 1ns/1ps

module tb_com_to_in;

  localparam int unsigned OS = 16;
`ifdef COM_RX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  // Ticks from driving the start edge to the stop-bit sample: 1 tick to
  // detect, half a bit to the start mid-point, then FB-1 whole bits; up to
  // 2 extra ticks of synchronizer latency.
  localparam int unsigned LAG_MIN = 1 + OS / 2 + OS * (FB - 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       isReady;
  logic       parErr;
  logic       frameErr;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    int unsigned st;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned tick_cnt = 0;
  int unsigned pulses = 0;
  int unsigned frames_sent = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  com_to_in #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .rx      (rx),
    .data    (data),
    .isReady (isReady),
    .parErr  (parErr),
    .frameErr(frameErr)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      enable = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (enable) tick_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      while (!enable) @(posedge clk);
    end
  endtask

  // Sends one frame; abort_bits>0 drives only that many bits and expects nothing.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_v,
                            input int unsigned abort_bits);
    logic        bits[$];
    logic        pbit;
    exp_t        e;
    int unsigned nb;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    pbit = 1'b0;
`ifdef COM_RX_PARITY_EN
    pbit = (($countones(d) % 2) == 1) ^ bad_par;
    bits.push_back(pbit);
    e.pe = ((($countones(d) + int'(pbit)) % 2) != 0);
`else
    e.pe = 1'b0;
`endif
    bits.push_back(stop_v);
    e.d  = d;
    e.fe = !stop_v;
    nb = (abort_bits != 0) ? abort_bits : bits.size();
    @(negedge clk);
    e.st = tick_cnt;
    if (abort_bits == 0) begin
      exp_q.push_back(e);
      frames_sent++;
    end
    for (int unsigned k = 0; k < nb; k++) begin
      if (k != 0) @(negedge clk);
      rx = bits[k];
      wait_ticks(OS);
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Monitor: every isReady pulse must match the oldest outstanding frame.
  initial begin
    logic        prev = 1'b0;
    exp_t        e;
    int unsigned lag;
    forever begin
      @(negedge clk);
      if (isReady) begin
        check("rdy_1cyc", prev, 0);
        check("rdy_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", data, e.d);
          check("parErr", parErr, e.pe);
          check("frameErr", frameErr, e.fe);
          lag = tick_cnt - e.st;
          check("frame_timing", (lag >= LAG_MIN) && (lag <= LAG_MIN + 2), 1);
        end
        pulses++;
      end
      prev = isReady;
    end
  end

  initial begin
    int unsigned p0;
    logic [7:0]  sweep[4];
    sweep[0] = 8'h00; sweep[1] = 8'hFF; sweep[2] = 8'h55; sweep[3] = 8'h81;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_rdy", isReady, 0);
    check("rst_pe", parErr, 0);
    check("rst_fe", frameErr, 0);
    reset = 1'b0;
    wait_ticks(20);

    // Frame with bad parity so outputs are non-zero, then abort mid-DATA
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    drain();
    send_frame(8'h77, 1'b0, 1'b1, 4);
    #2 reset = 1'b1;
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_rdy", isReady, 0);
    check("midrst_pe", parErr, 0);
    check("midrst_fe", frameErr, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    wait_ticks(5);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    drain();

    // Data sweep, back-to-back
    for (int i = 0; i < 4; i++) send_frame(sweep[i], 1'b0, 1'b1, 0);
    drain();

    // Parity bit wrong, then right
    send_frame(8'h03, 1'b1, 1'b1, 0);
    send_frame(8'h03, 1'b0, 1'b1, 0);
    drain();

    // False start: 4-tick low pulse while idle
    p0 = pulses;
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(3 * OS);
    check("false_start", pulses, p0);

    // Framing error followed by a long break
    p0 = pulses;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    wait_ticks(30 * OS);
    check("break_pulses", pulses, p0 + 1);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h42, 1'b0, 1'b1, 0);
    drain();

    // Randomized frames with random idle gaps
    for (int i = 0; i < 12; i++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b1, 0);
      wait_ticks($urandom_range(0, 20));
    end
    drain();

    // Zero-gap pair
    send_frame(8'hC3, 1'b0, 1'b1, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 0);
    wait_ticks(3 * OS);
    check("queue_empty", exp_q.size(), 0);
    check("pulse_total", pulses, frames_sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
